// File: rtl/gray2bin_rr_arbiter.sv
// gray2bin_rr_arbiter
//   One registered Gray-to-binary conversion stage shared by N_REQ requesters
//   under round-robin arbitration. The winner's Gray word is converted and
//   captured into a single output register offered on a valid/ready port.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req         per-requester request, held until granted
//   g_in        packed Gray words, requester k at [k*W +: W]
//   gnt         one-hot combinational accept pulse
//   out_valid   output register holds an unconsumed word
//   out_ready   consumer accepts when out_valid && out_ready
//   out_bin     binary result
//   out_id      index of the requester that produced out_bin
//   conv_count  saturating count of accepted conversions
module gray2bin_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int IDW   = 2,
  parameter int CW    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] g_in,
  output logic [N_REQ-1:0]   gnt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_bin,
  output logic [IDW-1:0]     out_id,
  output logic [CW-1:0]      conv_count
);

  logic [IDW-1:0] ptr_reg;
  logic           valid_reg;
  logic [W-1:0]   bin_reg;
  logic [IDW-1:0] id_reg;
  logic [CW-1:0]  count_reg;

  logic [IDW-1:0] winner;
  logic           found;
  logic [IDW:0]   cand_sum;
  logic [IDW-1:0] cand;
  logic           slot_free;
  logic           accept;
  logic [IDW-1:0] ptr_next;
  logic [W-1:0]   g_sel;
  logic [W-1:0]   bin_next;
  logic [W-1:0]   g_word [N_REQ];

  // Unpack the flat Gray bus into one word per requester.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign g_word[gi] = g_in[gi*W +: W];
    end
  endgenerate

  // Round-robin search: walk ptr, ptr+1, ... modulo N_REQ and take the first
  // active request. The sum is one bit wider so the wrap works for any N_REQ.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_sum = {1'b0, ptr_reg} + (IDW+1)'(i);
      if (cand_sum >= (IDW+1)'(N_REQ)) begin
        cand_sum = cand_sum - (IDW+1)'(N_REQ);
      end
      cand = cand_sum[IDW-1:0];
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // The slot frees up either when empty or when the current word drains in
  // this very cycle, which gives back-to-back throughput without a bubble.
  assign slot_free = !valid_reg || out_ready;
  assign accept    = rst_n && slot_free && found;

  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_gnt
      assign gnt[gi] = accept && (winner == IDW'(gi));
    end
  endgenerate

  assign ptr_next = (winner == IDW'(N_REQ-1)) ? '0 : winner + IDW'(1);

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  assign g_sel = g_word[winner];
  generate
    for (gi = 0; gi < W; gi++) begin : g_conv
      assign bin_next[gi] = ^g_sel[W-1:gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg   <= '0;
      valid_reg <= 1'b0;
      bin_reg   <= '0;
      id_reg    <= '0;
      count_reg <= '0;
    end else if (accept) begin
      ptr_reg   <= ptr_next;
      valid_reg <= 1'b1;
      bin_reg   <= bin_next;
      id_reg    <= winner;
      if (count_reg != '1) begin
        count_reg <= count_reg + CW'(1);
      end
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid  = valid_reg;
  assign out_bin    = bin_reg;
  assign out_id     = id_reg;
  assign conv_count = count_reg;

endmodule
